// File: rtl/r4_frame_sequencer_if.sv
// Sample-in / result-out streaming bundle between the radix-4 frame sequencer and its neighbours.
interface r4_frame_sequencer_if #(
    parameter int unsigned DW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_re;
    logic [DW-1:0] in_im;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_re;
    logic [DW-1:0] out_im;
    logic [1:0]    out_bin;

    // Sample source / result consumer side
    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_bin
    );

    // Sequencer side
    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_bin
    );
endinterface

// File: rtl/r4_frame_sequencer.sv
// Assembles 4-sample frames for the radix-4 butterfly, steps its bin selects and
// streams each registered bin result out over a valid/ready handshake.
module r4_frame_sequencer #(
    parameter int unsigned DW     = 4,
    parameter int unsigned FCNT_W = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rstn_i,
    input  logic              flush,
    r4_frame_sequencer_if.slave io,
    output logic [DW-1:0]     bf_xr0,
    output logic [DW-1:0]     bf_xr1,
    output logic [DW-1:0]     bf_xr2,
    output logic [DW-1:0]     bf_xr3,
    output logic [DW-1:0]     bf_xi0,
    output logic [DW-1:0]     bf_xi1,
    output logic [DW-1:0]     bf_xi2,
    output logic [DW-1:0]     bf_xi3,
    output logic              bf_c1,
    output logic              bf_c2,
    output logic              bf_c3,
    input  logic [DW-1:0]     bf_xro,
    input  logic [DW-1:0]     bf_xio,
    output logic [FCNT_W-1:0] frame_cnt
);
    localparam int unsigned IW = 2;
    localparam int unsigned NS = 4;
    localparam int unsigned SW = 3;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_CALC = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     s_q, s_d;
    logic [IW-1:0]     b_q, b_d;
    logic [DW-1:0]     xr_q [NS];
    logic [DW-1:0]     xr_d [NS];
    logic [DW-1:0]     xi_q [NS];
    logic [DW-1:0]     xi_d [NS];
    logic [DW-1:0]     out_re_q, out_re_d;
    logic [DW-1:0]     out_im_q, out_im_d;
    logic [IW-1:0]     out_bin_q, out_bin_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic [SW-1:0]     sel_q, sel_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              accept_c;
    logic              out_hs_c;

    // {c1,c2,c3} one-hot per bin, all-zero for bin 0
    function automatic logic [SW-1:0] sel_code(input logic [IW-1:0] bin);
        case (bin)
            2'd1:    return 3'b100;
            2'd2:    return 3'b010;
            2'd3:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    assign accept_c = io.in_valid & in_ready_q;
    assign out_hs_c = out_valid_q & io.out_ready;

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        b_d         = b_q;
        xr_d        = xr_q;
        xi_d        = xi_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        out_bin_d   = out_bin_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        sel_d       = '0;
        fcnt_d      = fcnt_q;

        // flush outranks any sample acceptance or result handshake this cycle
        if (flush) begin
            state_d     = ST_FILL;
            s_d         = '0;
            b_d         = '0;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
        end else begin
            case (state_q)
                ST_FILL: begin
                    in_ready_d = 1'b1;
                    if (accept_c) begin
                        xr_d[s_q] = io.in_re;
                        xi_d[s_q] = io.in_im;
                        s_d       = s_q + IW'(1);
                        if (s_q == IW'(NS - 1)) begin
                            b_d        = '0;
                            state_d    = ST_CALC;
                            in_ready_d = 1'b0;
                            sel_d      = sel_code('0);
                        end
                    end
                end
                ST_CALC: begin
                    out_re_d    = bf_xro;
                    out_im_d    = bf_xio;
                    out_bin_d   = b_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_hs_c) begin
                        out_valid_d = 1'b0;
                        if (b_q != IW'(NS - 1)) begin
                            b_d     = b_q + IW'(1);
                            state_d = ST_CALC;
                            sel_d   = sel_code(b_q + IW'(1));
                        end else begin
                            fcnt_d     = fcnt_q + FCNT_W'(1);
                            state_d    = ST_FILL;
                            in_ready_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d    = ST_FILL;
                    in_ready_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            state_q     <= ST_FILL;
            s_q         <= '0;
            b_q         <= '0;
            for (int i = 0; i < NS; i++) begin
                xr_q[i] <= '0;
                xi_q[i] <= '0;
            end
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_bin_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            sel_q       <= '0;
            fcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            b_q         <= b_d;
            xr_q        <= xr_d;
            xi_q        <= xi_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            out_bin_q   <= out_bin_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            sel_q       <= sel_d;
            fcnt_q      <= fcnt_d;
        end
    end

    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.out_re    = out_re_q;
    assign io.out_im    = out_im_q;
    assign io.out_bin   = out_bin_q;
    assign bf_xr0       = xr_q[0];
    assign bf_xr1       = xr_q[1];
    assign bf_xr2       = xr_q[2];
    assign bf_xr3       = xr_q[3];
    assign bf_xi0       = xi_q[0];
    assign bf_xi1       = xi_q[1];
    assign bf_xi2       = xi_q[2];
    assign bf_xi3       = xi_q[3];
    assign {bf_c1, bf_c2, bf_c3} = sel_q;
    assign frame_cnt    = fcnt_q;
endmodule

// File: tb/tb_r4_frame_sequencer.sv
// Self-checking bench for r4_frame_sequencer using a stub butterfly that returns sample k for bin k.
module tb_r4_frame_sequencer;
    localparam int unsigned DW     = 4;
    localparam int unsigned FCNT_W = 2;

    logic clk = 1'b0;
    logic rstn;
    logic flush;
    logic [DW-1:0] bf_xr0, bf_xr1, bf_xr2, bf_xr3;
    logic [DW-1:0] bf_xi0, bf_xi1, bf_xi2, bf_xi3;
    logic bf_c1, bf_c2, bf_c3;
    logic [DW-1:0] bf_xro, bf_xio;
    logic [FCNT_W-1:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    logic [DW-1:0] cur_re [4];
    logic [DW-1:0] cur_im [4];
    logic [DW-1:0] got_re [4];
    logic [DW-1:0] got_im [4];
    logic [1:0]    got_bin [4];
    logic [2:0]    sel_tab [4] = '{3'b000, 3'b100, 3'b010, 3'b001};

    r4_frame_sequencer_if #(.DW(DW)) ifc ();

    r4_frame_sequencer #(.DW(DW), .FCNT_W(FCNT_W)) dut (
        .wb_clk_i(clk), .wb_rstn_i(rstn), .flush(flush), .io(ifc.slave),
        .bf_xr0(bf_xr0), .bf_xr1(bf_xr1), .bf_xr2(bf_xr2), .bf_xr3(bf_xr3),
        .bf_xi0(bf_xi0), .bf_xi1(bf_xi1), .bf_xi2(bf_xi2), .bf_xi3(bf_xi3),
        .bf_c1(bf_c1), .bf_c2(bf_c2), .bf_c3(bf_c3),
        .bf_xro(bf_xro), .bf_xio(bf_xio), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Stub butterfly: bin k returns x[k]
    always_comb begin
        case ({bf_c1, bf_c2, bf_c3})
            3'b100:  begin bf_xro = bf_xr1; bf_xio = bf_xi1; end
            3'b010:  begin bf_xro = bf_xr2; bf_xio = bf_xi2; end
            3'b001:  begin bf_xro = bf_xr3; bf_xio = bf_xi3; end
            default: begin bf_xro = bf_xr0; bf_xio = bf_xi0; end
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_frame();
        for (int i = 0; i < 4; i++) begin
            cur_re[i] = DW'($urandom_range(0, 15));
            cur_im[i] = DW'($urandom_range(0, 15));
        end
    endtask

    task automatic send_sample(input logic [DW-1:0] re, input logic [DW-1:0] im,
                               input int gap, output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        ifc.in_valid = 1'b0;
        repeat (gap) tick();
        ifc.in_valid = 1'b1;
        ifc.in_re = re;
        ifc.in_im = im;
        while (!ok && n < 50) begin
            ok = (ifc.in_ready === 1'b1);
            tick();
            n++;
        end
        ifc.in_valid = 1'b0;
    endtask

    task automatic send_frame(input int max_gap, output bit ok);
        bit one;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_sample(cur_re[i], cur_im[i], $urandom_range(0, max_gap), one);
            ok = ok & one;
        end
    endtask

    task automatic collect_frame(input bit rand_stall, output bit ok);
        int n;
        int got;
        bit hs;
        n = 0;
        got = 0;
        while (got < 4 && n < 200) begin
            ifc.out_ready = rand_stall ? 1'($urandom_range(0, 1)) : 1'b1;
            hs = (ifc.out_valid === 1'b1) && ifc.out_ready;
            if (hs) begin
                got_re[got]  = ifc.out_re;
                got_im[got]  = ifc.out_im;
                got_bin[got] = ifc.out_bin;
            end
            tick();
            if (hs) got++;
            n++;
        end
        ifc.out_ready = 1'b0;
        ok = (got == 4);
    endtask

    task automatic test_reset();
        logic [8*DW-1:0] bfv;
        ifc.in_valid = 1'b1;
        ifc.in_re = 4'hA;
        ifc.in_im = 4'h5;
        rstn = 1'b0;
        tick();
        tick();
        bfv = {bf_xr0, bf_xr1, bf_xr2, bf_xr3, bf_xi0, bf_xi1, bf_xi2, bf_xi3};
        checks++;
        if (bfv !== '0) begin errors++; $display("FAIL reset_bf got %h exp 0", bfv); end
        checks++;
        if ({ifc.out_valid, ifc.in_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_vr got %b exp 00", {ifc.out_valid, ifc.in_ready});
        end
        checks++;
        if ({ifc.out_re, ifc.out_im, ifc.out_bin} !== '0 || frame_cnt !== '0) begin
            errors++; $display("FAIL reset_out got %h/%h/%h cnt %h exp 0", ifc.out_re, ifc.out_im, ifc.out_bin, frame_cnt);
        end
        checks++;
        if ({bf_c1, bf_c2, bf_c3} !== 3'b000) begin
            errors++; $display("FAIL reset_sel got %b exp 000", {bf_c1, bf_c2, bf_c3});
        end
        ifc.in_valid = 1'b0;
        rstn = 1'b1;
        tick();
        checks++;
        if (ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_release got rdy %b vld %b exp 1 0", ifc.in_ready, ifc.out_valid);
        end
        exp_cnt = 0;
    endtask

    task automatic test_single_frame();
        bit ok;
        logic [8*DW-1:0] bfv;
        cur_re = '{4'd1, 4'd3, 4'd5, 4'd7};
        cur_im = '{4'd2, 4'd4, 4'd6, 4'd8};
        ifc.out_ready = 1'b1;
        send_frame(0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_accept got timeout exp 4 accepts"); end
        bfv = {bf_xr0, bf_xr1, bf_xr2, bf_xr3, bf_xi0, bf_xi1, bf_xi2, bf_xi3};
        checks++;
        if (bfv !== 32'h1357_2468) begin errors++; $display("FAIL single_bf got %h exp 13572468", bfv); end
        checks++;
        if (ifc.in_ready !== 1'b0) begin errors++; $display("FAIL single_rdy_low got %b exp 0", ifc.in_ready); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ifc.out_valid !== 1'b0 || {bf_c1, bf_c2, bf_c3} !== sel_tab[k]) begin
                errors++; $display("FAIL single_calc%0d got vld %b sel %b exp 0 %b", k, ifc.out_valid, {bf_c1, bf_c2, bf_c3}, sel_tab[k]);
            end
            tick();
            checks++;
            if ({ifc.out_valid, ifc.out_re, ifc.out_im, ifc.out_bin} !== {1'b1, cur_re[k], cur_im[k], 2'(k)}) begin
                errors++; $display("FAIL single_bin%0d got %b %h %h %0d exp 1 %h %h %0d", k, ifc.out_valid, ifc.out_re, ifc.out_im, ifc.out_bin, cur_re[k], cur_im[k], k);
            end
            tick();
        end
        exp_cnt++;
        checks++;
        if (frame_cnt !== FCNT_W'(exp_cnt) || ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0) begin
            errors++; $display("FAIL single_end got cnt %0d rdy %b vld %b exp %0d 1 0", frame_cnt, ifc.in_ready, ifc.out_valid, FCNT_W'(exp_cnt));
        end
        ifc.out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        bit ok;
        int n;
        randomize_frame();
        ifc.out_ready = 1'b0;
        send_frame(0, ok);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (ifc.out_valid !== 1'b1 && n < 10) begin tick(); n++; end
            if (k == 1) begin
                for (int j = 0; j < 5; j++) begin
                    tick();
                    checks++;
                    if ({ifc.out_valid, ifc.in_ready, ifc.out_re, ifc.out_im, ifc.out_bin} !== {2'b10, cur_re[1], cur_im[1], 2'd1}) begin
                        errors++; $display("FAIL bp_hold%0d got %b%b %h %h %0d exp 10 %h %h 1", j, ifc.out_valid, ifc.in_ready, ifc.out_re, ifc.out_im, ifc.out_bin, cur_re[1], cur_im[1]);
                    end
                end
            end
            checks++;
            if ({ifc.out_valid, ifc.out_re, ifc.out_im, ifc.out_bin} !== {1'b1, cur_re[k], cur_im[k], 2'(k)}) begin
                errors++; $display("FAIL bp_bin%0d got %b %h %h %0d exp 1 %h %h %0d", k, ifc.out_valid, ifc.out_re, ifc.out_im, ifc.out_bin, cur_re[k], cur_im[k], k);
            end
            ifc.out_ready = 1'b1;
            tick();
            ifc.out_ready = 1'b0;
        end
        exp_cnt++;
        checks++;
        if (frame_cnt !== FCNT_W'(exp_cnt) || ifc.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_end got cnt %0d rdy %b exp %0d 1", frame_cnt, ifc.in_ready, FCNT_W'(exp_cnt));
        end
    endtask

    task automatic test_flush();
        bit ok;
        int n;
        ifc.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) send_sample(DW'($urandom_range(0, 15)), DW'($urandom_range(0, 15)), 0, ok);
        ifc.in_valid = 1'b1;
        ifc.in_re = DW'($urandom_range(0, 15));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        ifc.in_valid = 1'b0;
        checks++;
        if (ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0 || frame_cnt !== FCNT_W'(exp_cnt)) begin
            errors++; $display("FAIL flush_fill got rdy %b vld %b cnt %0d exp 1 0 %0d", ifc.in_ready, ifc.out_valid, frame_cnt, FCNT_W'(exp_cnt));
        end
        randomize_frame();
        send_frame(1, ok);
        collect_frame(1'b1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL flush_collect got timeout exp 4 results"); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({got_re[k], got_im[k], got_bin[k]} !== {cur_re[k], cur_im[k], 2'(k)}) begin
                errors++; $display("FAIL flush_fresh%0d got %h %h %0d exp %h %h %0d", k, got_re[k], got_im[k], got_bin[k], cur_re[k], cur_im[k], k);
            end
        end
        exp_cnt++;
        // Flush while bin2 is held and being accepted in the same cycle
        randomize_frame();
        send_frame(0, ok);
        ifc.out_ready = 1'b1;
        n = 0;
        while (!(ifc.out_valid === 1'b1 && ifc.out_bin === 2'd2) && n < 20) begin tick(); n++; end
        checks++;
        if (ifc.out_re !== cur_re[2] || ifc.out_im !== cur_im[2]) begin
            errors++; $display("FAIL flush_bin2 got %h %h exp %h %h", ifc.out_re, ifc.out_im, cur_re[2], cur_im[2]);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (ifc.out_valid !== 1'b0 || frame_cnt !== FCNT_W'(exp_cnt) || ifc.in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_hold got vld %b cnt %0d rdy %b exp 0 %0d 1", ifc.out_valid, frame_cnt, ifc.in_ready, FCNT_W'(exp_cnt));
        end
        tick();
        checks++;
        if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL flush_quiet got vld %b exp 0", ifc.out_valid); end
        ifc.out_ready = 1'b0;
    endtask

    task automatic test_random_frames();
        bit ok;
        for (int f = 0; f < 4; f++) begin
            randomize_frame();
            send_frame(2, ok);
            collect_frame(1'b1, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL rand_collect%0d got timeout exp 4 results", f); end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if ({got_re[k], got_im[k], got_bin[k]} !== {cur_re[k], cur_im[k], 2'(k)}) begin
                    errors++; $display("FAIL rand%0d_bin%0d got %h %h %0d exp %h %h %0d", f, k, got_re[k], got_im[k], got_bin[k], cur_re[k], cur_im[k], k);
                end
            end
            exp_cnt++;
            checks++;
            if (frame_cnt !== FCNT_W'(exp_cnt)) begin
                errors++; $display("FAIL rand%0d_cnt got %0d exp %0d", f, frame_cnt, FCNT_W'(exp_cnt));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] q_re [20];
        logic [DW-1:0] q_im [20];
        logic [DW-1:0] r_re [20];
        logic [DW-1:0] r_im [20];
        logic [1:0]    r_bin [20];
        int acc_cyc [5];
        int ptr, got, cyc;
        bit acc, hs;
        ifc.in_valid = 1'b0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        exp_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            q_re[i] = DW'($urandom_range(0, 15));
            q_im[i] = DW'($urandom_range(0, 15));
        end
        ptr = 0; got = 0; cyc = 0;
        ifc.out_ready = 1'b1;
        while (got < 20 && cyc < 400) begin
            ifc.in_valid = (ptr < 20);
            if (ptr < 20) begin ifc.in_re = q_re[ptr]; ifc.in_im = q_im[ptr]; end
            acc = ifc.in_valid && (ifc.in_ready === 1'b1);
            hs = (ifc.out_valid === 1'b1);
            if (hs) begin r_re[got] = ifc.out_re; r_im[got] = ifc.out_im; r_bin[got] = ifc.out_bin; end
            tick();
            cyc++;
            if (acc) begin
                if (ptr % 4 == 3) acc_cyc[ptr / 4] = cyc;
                ptr++;
            end
            if (hs) begin
                got++;
                if (got % 4 == 0) begin
                    exp_cnt++;
                    checks++;
                    if (frame_cnt !== FCNT_W'(exp_cnt)) begin
                        errors++; $display("FAIL b2b_cnt%0d got %0d exp %0d", got / 4, frame_cnt, FCNT_W'(exp_cnt));
                    end
                end
            end
        end
        ifc.in_valid = 1'b0;
        ifc.out_ready = 1'b0;
        checks++;
        if (got != 20 || ptr != 20) begin errors++; $display("FAIL b2b_count got %0d out %0d in exp 20 20", got, ptr); end
        for (int i = 0; i < got; i++) begin
            checks++;
            if ({r_re[i], r_im[i], r_bin[i]} !== {q_re[i], q_im[i], 2'(i % 4)}) begin
                errors++; $display("FAIL b2b_res%0d got %h %h %0d exp %h %h %0d", i, r_re[i], r_im[i], r_bin[i], q_re[i], q_im[i], i % 4);
            end
        end
        if (ptr == 20) begin
            for (int f = 0; f < 4; f++) begin
                checks++;
                if (acc_cyc[f + 1] - acc_cyc[f] != 12) begin
                    errors++; $display("FAIL b2b_spacing%0d got %0d exp 12", f, acc_cyc[f + 1] - acc_cyc[f]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_emit();
        bit ok;
        int n;
        randomize_frame();
        ifc.out_ready = 1'b1;
        send_frame(0, ok);
        n = 0;
        while (!(ifc.out_valid === 1'b1 && ifc.out_bin === 2'd0) && n < 10) begin tick(); n++; end
        tick();
        checks++;
        if (ifc.out_valid !== 1'b0 || {bf_c1, bf_c2, bf_c3} !== 3'b100) begin
            errors++; $display("FAIL rst_calc1 got vld %b sel %b exp 0 100", ifc.out_valid, {bf_c1, bf_c2, bf_c3});
        end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        checks++;
        if (ifc.out_valid !== 1'b0 || frame_cnt !== '0 || {bf_c1, bf_c2, bf_c3} !== 3'b000) begin
            errors++; $display("FAIL rst_mid got vld %b cnt %0d sel %b exp 0 0 000", ifc.out_valid, frame_cnt, {bf_c1, bf_c2, bf_c3});
        end
        tick();
        checks++;
        if (ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_fill got rdy %b vld %b exp 1 0", ifc.in_ready, ifc.out_valid);
        end
        exp_cnt = 0;
        randomize_frame();
        send_frame(0, ok);
        collect_frame(1'b0, ok);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({got_re[k], got_im[k], got_bin[k]} !== {cur_re[k], cur_im[k], 2'(k)}) begin
                errors++; $display("FAIL rst_next%0d got %h %h %0d exp %h %h %0d", k, got_re[k], got_im[k], got_bin[k], cur_re[k], cur_im[k], k);
            end
        end
        exp_cnt++;
        checks++;
        if (frame_cnt !== FCNT_W'(exp_cnt)) begin
            errors++; $display("FAIL rst_next_cnt got %0d exp %0d", frame_cnt, FCNT_W'(exp_cnt));
        end
    endtask

    initial begin
        rstn = 1'b0;
        flush = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.in_re = '0;
        ifc.in_im = '0;
        ifc.out_ready = 1'b0;
        test_reset();
        test_single_frame();
        test_backpressure();
        test_flush();
        test_random_frames();
        test_back_to_back();
        test_reset_mid_emit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
